// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - ID/EX pipeline register and issue controller with forwarding and multiply stall
module ex_issue_ctrl #(
  parameter int MULT_CYCLES = 3,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [6:0]  id_alu_sel,
  input  logic [4:0]  id_immed5,
  input  logic [31:0] id_immed32,
  input  logic        id_immed_sel,
  input  logic        id_shift,
  input  logic        id_sh_dir,
  input  logic [2:0]  id_sh_func,
  input  logic        id_mult,
  input  logic        id_PSR_Wen,
  input  logic        id_wr_en,
  input  logic [3:0]  id_rd,
  input  logic [3:0]  id_rs_a,
  input  logic [3:0]  id_rs_b,
  input  logic [31:0] id_srcA,
  input  logic [31:0] id_srcB,
  input  logic [31:0] ex_data,
  output logic [6:0]  ex_alu_sel,
  output logic [4:0]  ex_immed5,
  output logic [31:0] ex_immed32,
  output logic        ex_immed_sel,
  output logic        ex_shift,
  output logic        ex_sh_dir,
  output logic [2:0]  ex_sh_func,
  output logic        ex_mult,
  output logic [31:0] ex_srcA,
  output logic [31:0] ex_srcB,
  output logic        ex_PSR_Wen,
  output logic        ex_valid,
  output logic        wb_valid,
  output logic        wb_wr_en,
  output logic [3:0]  wb_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        alu_sel_q, alu_sel_d;
  logic [4:0]        immed5_q, immed5_d;
  logic [31:0]       immed32_q, immed32_d;
  logic              immed_sel_q, immed_sel_d;
  logic              shift_q, shift_d;
  logic              sh_dir_q, sh_dir_d;
  logic [2:0]        sh_func_q, sh_func_d;
  logic              mult_q, mult_d;
  logic              psr_wen_q, psr_wen_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        rd_q, rd_d;
  logic [31:0]       src_a_q, src_a_d;
  logic [31:0]       src_b_q, src_b_d;

  logic              transfer;
  logic              fwd_a;
  logic              fwd_b;

  // ID is blocked only while a multiply is still grinding in EX
  assign id_ready = !resetn && !flush && (state_q != MWAIT);
  assign transfer = id_valid && id_ready;

  assign ex_valid = (state_q != IDLE);
  assign wb_valid = (state_q == RUN);

  // The result sitting in EX this cycle is final only when wb_valid; rd 0 is not special
  assign fwd_a = wb_valid && wr_en_q && (rd_q == id_rs_a);
  assign fwd_b = wb_valid && wr_en_q && (rd_q == id_rs_b);

  // Next-state and next-contents of the EX stage; flush beats transfer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_sel_d   = alu_sel_q;
    immed5_d    = immed5_q;
    immed32_d   = immed32_q;
    immed_sel_d = immed_sel_q;
    shift_d     = shift_q;
    sh_dir_d    = sh_dir_q;
    sh_func_d   = sh_func_q;
    mult_d      = mult_q;
    psr_wen_d   = psr_wen_q;
    wr_en_d     = wr_en_q;
    rd_d        = rd_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;

    if (flush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      psr_wen_d = 1'b0;
      wr_en_d   = 1'b0;
    end else if (transfer) begin
      alu_sel_d   = id_alu_sel;
      immed5_d    = id_immed5;
      immed32_d   = id_immed32;
      immed_sel_d = id_immed_sel;
      shift_d     = id_shift;
      sh_dir_d    = id_sh_dir;
      sh_func_d   = id_sh_func;
      mult_d      = id_mult;
      psr_wen_d   = id_PSR_Wen;
      wr_en_d     = id_wr_en;
      rd_d        = id_rd;
      src_a_d     = fwd_a ? ex_data : id_srcA;
      src_b_d     = fwd_b ? ex_data : id_srcB;
      if (id_mult && (MULT_CYCLES > 1)) begin
        state_d = MWAIT;
        cnt_d   = CNT_W'(MULT_CYCLES - 1);
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (state_q == MWAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = RUN;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // EX stage register; reset clears data as well as control
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_sel_q   <= '0;
      immed5_q    <= '0;
      immed32_q   <= '0;
      immed_sel_q <= 1'b0;
      shift_q     <= 1'b0;
      sh_dir_q    <= 1'b0;
      sh_func_q   <= '0;
      mult_q      <= 1'b0;
      psr_wen_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_q        <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_sel_q   <= alu_sel_d;
      immed5_q    <= immed5_d;
      immed32_q   <= immed32_d;
      immed_sel_q <= immed_sel_d;
      shift_q     <= shift_d;
      sh_dir_q    <= sh_dir_d;
      sh_func_q   <= sh_func_d;
      mult_q      <= mult_d;
      psr_wen_q   <= psr_wen_d;
      wr_en_q     <= wr_en_d;
      rd_q        <= rd_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
    end
  end

  assign ex_alu_sel   = alu_sel_q;
  assign ex_immed5    = immed5_q;
  assign ex_immed32   = immed32_q;
  assign ex_immed_sel = immed_sel_q;
  assign ex_shift     = shift_q;
  assign ex_sh_dir    = sh_dir_q;
  assign ex_sh_func   = sh_func_q;
  assign ex_mult      = mult_q;
  assign ex_srcA      = src_a_q;
  assign ex_srcB      = src_b_q;
  assign ex_PSR_Wen   = psr_wen_q && wb_valid;
  assign wb_wr_en     = wr_en_q && wb_valid;
  assign wb_rd        = rd_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb/tb_ex_issue_ctrl.sv - randomized self-checking bench for ex_issue_ctrl
module tb_ex_issue_ctrl;

  localparam int MC = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic [6:0]  id_alu_sel = '0;
  logic [4:0]  id_immed5 = '0;
  logic [31:0] id_immed32 = '0;
  logic        id_immed_sel = 1'b0;
  logic        id_shift = 1'b0;
  logic        id_sh_dir = 1'b0;
  logic [2:0]  id_sh_func = '0;
  logic        id_mult = 1'b0;
  logic        id_PSR_Wen = 1'b0;
  logic        id_wr_en = 1'b0;
  logic [3:0]  id_rd = '0;
  logic [3:0]  id_rs_a = '0;
  logic [3:0]  id_rs_b = '0;
  logic [31:0] id_srcA = '0;
  logic [31:0] id_srcB = '0;
  logic [31:0] ex_data = '0;

  logic        id_ready, ex_immed_sel, ex_shift, ex_sh_dir, ex_mult;
  logic        ex_PSR_Wen, ex_valid, wb_valid, wb_wr_en;
  logic [6:0]  ex_alu_sel;
  logic [4:0]  ex_immed5;
  logic [31:0] ex_immed32, ex_srcA, ex_srcB;
  logic [2:0]  ex_sh_func;
  logic [3:0]  wb_rd;

  logic        id_ready1, ex_immed_sel1, ex_shift1, ex_sh_dir1, ex_mult1;
  logic        ex_PSR_Wen1, ex_valid1, wb_valid1, wb_wr_en1;
  logic [6:0]  ex_alu_sel1;
  logic [4:0]  ex_immed51;
  logic [31:0] ex_immed321, ex_srcA1, ex_srcB1;
  logic [2:0]  ex_sh_func1;
  logic [3:0]  wb_rd1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ex_issue_ctrl #(.MULT_CYCLES(MC), .CNT_W(2)) u_dut (
    .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_alu_sel(id_alu_sel), .id_immed5(id_immed5), .id_immed32(id_immed32),
    .id_immed_sel(id_immed_sel), .id_shift(id_shift), .id_sh_dir(id_sh_dir),
    .id_sh_func(id_sh_func), .id_mult(id_mult), .id_PSR_Wen(id_PSR_Wen), .id_wr_en(id_wr_en),
    .id_rd(id_rd), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_srcA(id_srcA), .id_srcB(id_srcB),
    .ex_data(ex_data), .ex_alu_sel(ex_alu_sel), .ex_immed5(ex_immed5), .ex_immed32(ex_immed32),
    .ex_immed_sel(ex_immed_sel), .ex_shift(ex_shift), .ex_sh_dir(ex_sh_dir),
    .ex_sh_func(ex_sh_func), .ex_mult(ex_mult), .ex_srcA(ex_srcA), .ex_srcB(ex_srcB),
    .ex_PSR_Wen(ex_PSR_Wen), .ex_valid(ex_valid), .wb_valid(wb_valid), .wb_wr_en(wb_wr_en),
    .wb_rd(wb_rd)
  );

  ex_issue_ctrl #(.MULT_CYCLES(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid), .id_ready(id_ready1),
    .id_alu_sel(id_alu_sel), .id_immed5(id_immed5), .id_immed32(id_immed32),
    .id_immed_sel(id_immed_sel), .id_shift(id_shift), .id_sh_dir(id_sh_dir),
    .id_sh_func(id_sh_func), .id_mult(id_mult), .id_PSR_Wen(id_PSR_Wen), .id_wr_en(id_wr_en),
    .id_rd(id_rd), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_srcA(id_srcA), .id_srcB(id_srcB),
    .ex_data(ex_data), .ex_alu_sel(ex_alu_sel1), .ex_immed5(ex_immed51), .ex_immed32(ex_immed321),
    .ex_immed_sel(ex_immed_sel1), .ex_shift(ex_shift1), .ex_sh_dir(ex_sh_dir1),
    .ex_sh_func(ex_sh_func1), .ex_mult(ex_mult1), .ex_srcA(ex_srcA1), .ex_srcB(ex_srcB1),
    .ex_PSR_Wen(ex_PSR_Wen1), .ex_valid(ex_valid1), .wb_valid(wb_valid1), .wb_wr_en(wb_wr_en1),
    .wb_rd(wb_rd1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_alu_sel = 0; id_immed5 = 0; id_immed32 = 0; id_immed_sel = 0;
    id_shift = 0; id_sh_dir = 0; id_sh_func = 0; id_mult = 0; id_PSR_Wen = 0; id_wr_en = 0;
    id_rd = 0; id_rs_a = 0; id_rs_b = 0; id_srcA = 0; id_srcB = 0;
  endtask

  task automatic offer(input logic [6:0] alu, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] a, input logic [31:0] b,
                       input logic mul, input logic psr, input logic wr);
    id_valid = 1; id_alu_sel = alu; id_rd = rd; id_rs_a = ra; id_rs_b = rb;
    id_srcA = a; id_srcB = b; id_mult = mul; id_PSR_Wen = psr; id_wr_en = wr;
  endtask

  task automatic test_reset();
    id_clear();
    resetn = 1; flush = 0;
    offer(7'h11, 4'd1, 4'd2, 4'd3, 32'd1, 32'd2, 1'b0, 1'b1, 1'b1);
    cyc();
    total++;
    if (id_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", id_ready); end
    cyc();
    resetn = 0;
    id_clear();
    #1;
    total++;
    if ({ex_valid, wb_valid, wb_wr_en, ex_PSR_Wen, wb_rd, ex_alu_sel, ex_srcA, ex_srcB, ex_mult, ex_immed32} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b%b%b%b srcA=%h srcB=%h exp=0", ex_valid, wb_valid, wb_wr_en, ex_PSR_Wen, ex_srcA, ex_srcB);
    end
    total++;
    if (id_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", id_ready); end
    cyc();
    total++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin bad++; $display("FAIL idle_after_reset ex_valid=%b id_ready=%b exp 0/1", ex_valid, id_ready); end
  endtask

  task automatic test_forward_chain();
    offer(7'h01, 4'd3, 4'd1, 4'd2, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);
    cyc();
    ex_data = 32'd12;
    offer(7'h02, 4'd4, 4'd3, 4'd3, 32'd99, 32'd98, 1'b0, 1'b0, 1'b1);
    #1;
    total++;
    if (wb_valid !== 1'b1 || wb_wr_en !== 1'b1 || wb_rd !== 4'd3 || ex_srcA !== 32'd5 || ex_srcB !== 32'd7) begin
      bad++; $display("FAIL fwd_first wb=%b wr=%b rd=%0d A=%0d B=%0d exp 1 1 3 5 7", wb_valid, wb_wr_en, wb_rd, ex_srcA, ex_srcB);
    end
    cyc();
    id_clear();
    #1;
    total++;
    if (ex_srcA !== 32'd12 || ex_srcB !== 32'd12 || wb_valid !== 1'b1 || ex_alu_sel !== 7'h02) begin
      bad++; $display("FAIL fwd_second A=%0d B=%0d wb=%b alu=%h exp 12 12 1 02", ex_srcA, ex_srcB, wb_valid, ex_alu_sel);
    end
    cyc();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL fwd_drain ex_valid=%b exp=0", ex_valid); end
  endtask

  task automatic test_mult_stall();
    offer(7'h20, 4'd5, 4'd0, 4'd0, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1);
    cyc();
    offer(7'h09, 4'd6, 4'd0, 4'd0, 32'd8, 32'd9, 1'b0, 1'b0, 1'b1);
    #1;
    total++;
    if (id_ready !== 0 || wb_valid !== 0 || ex_PSR_Wen !== 0 || ex_valid !== 1 || ex_mult !== 1 || ex_srcA !== 32'd3) begin
      bad++; $display("FAIL mul_cycle1 rdy=%b wb=%b psr=%b v=%b m=%b A=%0d exp 0 0 0 1 1 3", id_ready, wb_valid, ex_PSR_Wen, ex_valid, ex_mult, ex_srcA);
    end
    cyc();
    total++;
    if (id_ready !== 0 || wb_valid !== 0 || ex_PSR_Wen !== 0 || ex_srcA !== 32'd3 || ex_alu_sel !== 7'h20) begin
      bad++; $display("FAIL mul_cycle2 rdy=%b wb=%b psr=%b A=%0d alu=%h exp 0 0 0 3 20", id_ready, wb_valid, ex_PSR_Wen, ex_srcA, ex_alu_sel);
    end
    cyc();
    total++;
    if (id_ready !== 1 || wb_valid !== 1 || ex_PSR_Wen !== 1 || wb_wr_en !== 1 || ex_alu_sel !== 7'h20) begin
      bad++; $display("FAIL mul_cycle3 rdy=%b wb=%b psr=%b wr=%b alu=%h exp 1 1 1 1 20", id_ready, wb_valid, ex_PSR_Wen, wb_wr_en, ex_alu_sel);
    end
    cyc();
    id_clear();
    #1;
    total++;
    if (ex_alu_sel !== 7'h09 || ex_mult !== 0 || wb_valid !== 1 || ex_PSR_Wen !== 0 || ex_srcA !== 32'd8) begin
      bad++; $display("FAIL mul_next_load alu=%h m=%b wb=%b psr=%b A=%0d exp 09 0 1 0 8", ex_alu_sel, ex_mult, wb_valid, ex_PSR_Wen, ex_srcA);
    end
    cyc();
  endtask

  task automatic test_flush_mwait();
    offer(7'h20, 4'd5, 4'd0, 4'd0, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1);
    cyc();
    offer(7'h07, 4'd2, 4'd0, 4'd0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    cyc();
    flush = 1;
    #1;
    total++;
    if (id_ready !== 0 || wb_valid !== 0 || ex_PSR_Wen !== 0) begin
      bad++; $display("FAIL flush_cycle rdy=%b wb=%b psr=%b exp 0 0 0", id_ready, wb_valid, ex_PSR_Wen);
    end
    cyc();
    flush = 0;
    #1;
    total++;
    if (ex_valid !== 0 || wb_valid !== 0 || ex_PSR_Wen !== 0 || wb_wr_en !== 0 || id_ready !== 1) begin
      bad++; $display("FAIL flush_after v=%b wb=%b psr=%b wr=%b rdy=%b exp 0 0 0 0 1", ex_valid, wb_valid, ex_PSR_Wen, wb_wr_en, id_ready);
    end
    cyc();
    id_clear();
    #1;
    total++;
    if (ex_alu_sel !== 7'h07 || ex_valid !== 1 || wb_valid !== 1 || ex_mult !== 0) begin
      bad++; $display("FAIL flush_pending_issue alu=%h v=%b wb=%b m=%b exp 07 1 1 0", ex_alu_sel, ex_valid, wb_valid, ex_mult);
    end
    cyc();
  endtask

  task automatic test_bubble();
    offer(7'h01, 4'd2, 4'd0, 4'd0, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
    cyc();
    id_clear();
    #1;
    total++;
    if (ex_PSR_Wen !== 1 || wb_wr_en !== 0 || wb_valid !== 1) begin
      bad++; $display("FAIL bubble_first psr=%b wr=%b wb=%b exp 1 0 1", ex_PSR_Wen, wb_wr_en, wb_valid);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++;
      if (ex_PSR_Wen !== 0 || ex_valid !== 0 || wb_wr_en !== 0) begin
        bad++; $display("FAIL bubble_idle%0d psr=%b v=%b wr=%b exp 0 0 0", i, ex_PSR_Wen, ex_valid, wb_wr_en);
      end
    end
  endtask

  task automatic test_mult1();
    for (int i = 0; i < 5; i++) begin
      offer(7'h20, 4'(i + 1), 4'd0, 4'd0, 32'(i), 32'(i), 1'b1, 1'b1, 1'b0);
      #1;
      total++;
      if (id_ready1 !== 1'b1) begin bad++; $display("FAIL mult1_ready%0d got=%b exp=1", i, id_ready1); end
      if (i > 0) begin
        total++;
        if (wb_valid1 !== 1 || ex_mult1 !== 1 || ex_PSR_Wen1 !== 1 || wb_rd1 !== 4'(i)) begin
          bad++; $display("FAIL mult1_issue%0d wb=%b m=%b psr=%b rd=%0d exp 1 1 1 %0d", i, wb_valid1, ex_mult1, ex_PSR_Wen1, wb_rd1, i);
        end
      end
      cyc();
    end
    id_clear();
    repeat (4) cyc();
  endtask

  // Reference model: EX slot holding one instruction and the cycles it still needs
  logic        m_live;
  int          m_rem;
  logic [6:0]  m_alu;
  logic [4:0]  m_i5;
  logic [31:0] m_i32, m_a, m_b;
  logic        m_isel, m_sh, m_dir, m_mul, m_psr, m_wr;
  logic [2:0]  m_fn;
  logic [3:0]  m_rd;

  task automatic test_random();
    logic [122:0] exp_v, got_v;
    logic         exp_rdy, m_wb;
    m_live = 0; m_rem = 0; m_alu = 0; m_i5 = 0; m_i32 = 0; m_a = 0; m_b = 0;
    m_isel = 0; m_sh = 0; m_dir = 0; m_mul = 0; m_psr = 0; m_wr = 0; m_fn = 0; m_rd = 0;
    id_clear();
    flush = 0; resetn = 1;
    cyc();
    resetn = 0;
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 7);
      id_valid = ($urandom_range(0, 99) < 75);
      id_alu_sel = 7'($urandom); id_immed5 = 5'($urandom); id_immed32 = $urandom;
      id_immed_sel = 1'($urandom); id_shift = 1'($urandom); id_sh_dir = 1'($urandom);
      id_sh_func = 3'($urandom); id_mult = ($urandom_range(0, 3) == 0);
      id_PSR_Wen = 1'($urandom); id_wr_en = 1'($urandom);
      id_rd = 4'($urandom_range(0, 3)); id_rs_a = 4'($urandom_range(0, 3)); id_rs_b = 4'($urandom_range(0, 3));
      id_srcA = $urandom; id_srcB = $urandom;
      ex_data = m_a + m_b;
      #1;
      m_wb = m_live && (m_rem == 1);
      exp_rdy = !resetn && !flush && !(m_live && m_rem > 1);
      exp_v = {m_live, m_wb, m_wb && m_wr, m_rd, m_wb && m_psr, m_alu, m_i5, m_i32,
               m_isel, m_sh, m_dir, m_fn, m_mul, m_a, m_b};
      got_v = {ex_valid, wb_valid, wb_wr_en, wb_rd, ex_PSR_Wen, ex_alu_sel, ex_immed5, ex_immed32,
               ex_immed_sel, ex_shift, ex_sh_dir, ex_sh_func, ex_mult, ex_srcA, ex_srcB};
      total++;
      if (id_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, id_ready, exp_rdy); end
      total++;
      if (got_v !== exp_v) begin bad++; $display("FAIL rand_outputs n=%0d got=%h exp=%h", n, got_v, exp_v); end
      if (resetn) begin
        m_live = 0; m_rem = 0; m_alu = 0; m_i5 = 0; m_i32 = 0; m_a = 0; m_b = 0;
        m_isel = 0; m_sh = 0; m_dir = 0; m_mul = 0; m_psr = 0; m_wr = 0; m_fn = 0; m_rd = 0;
      end else if (flush) begin
        m_live = 0; m_rem = 0; m_psr = 0; m_wr = 0;
      end else if (id_valid && exp_rdy) begin
        m_a = (m_wb && m_wr && m_rd == id_rs_a) ? ex_data : id_srcA;
        m_b = (m_wb && m_wr && m_rd == id_rs_b) ? ex_data : id_srcB;
        m_alu = id_alu_sel; m_i5 = id_immed5; m_i32 = id_immed32; m_isel = id_immed_sel;
        m_sh = id_shift; m_dir = id_sh_dir; m_fn = id_sh_func; m_mul = id_mult;
        m_psr = id_PSR_Wen; m_wr = id_wr_en; m_rd = id_rd;
        m_live = 1; m_rem = id_mult ? MC : 1;
      end else if (m_live && m_rem > 1) begin
        m_rem = m_rem - 1;
      end else begin
        m_live = 0;
      end
      cyc();
    end
    resetn = 0; flush = 0;
    id_clear();
  endtask

  initial begin
    cyc();
    test_reset();
    test_forward_chain();
    test_mult_stall();
    test_flush_mwait();
    test_bubble();
    test_mult1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
- ID/EX pipeline register and issue controller. Drives every control and operand input of the execute datapath.
- Takes a decoded instruction from ID under a valid/ready handshake and registers it into EX.
- Forwards the EX result into dependent operands.
- Holds EX stable for multi-cycle multiplies.
- Kills in-flight work on flush.

Parameters:
- MULT_CYCLES, 3, cycles a multiply occupies EX (>=1; 1 = no stall)
- CNT_W, 2, width of multiply wait counter (must hold MULT_CYCLES-1)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-high (asserted = 1)
- flush  in  1  kill EX contents and drop ID offer this cycle
- id_valid  in  1  ID offers an instruction
- id_ready  out  1  controller accepts the offer this cycle
- id_alu_sel  in  7  ALU op
- id_immed5  in  5  immediate shift amount
- id_immed32  in  32  extended immediate
- id_immed_sel  in  1  immediate replaces A
- id_shift  in  1  shifter op
- id_sh_dir  in  1  shift direction
- id_sh_func  in  3  shift function
- id_mult  in  1  multiply op
- id_PSR_Wen  in  1  update flags
- id_wr_en  in  1  writes register file
- id_rd  in  4  destination register
- id_rs_a  in  4  source register of srcA
- id_rs_b  in  4  source register of srcB
- id_srcA  in  32  register-file value A
- id_srcB  in  32  register-file value B
- ex_data  in  32  EX datapath data_out (combinational from current EX contents)
- ex_alu_sel, ex_immed5, ex_immed32, ex_immed_sel, ex_shift, ex_sh_dir, ex_sh_func, ex_mult  out  (widths as id_)  registered EX controls
- ex_srcA, ex_srcB  out  32  registered, forwarded operands
- ex_PSR_Wen  out  1  flag write, gated by valid and completion
- ex_valid  out  1  EX holds a live instruction
- wb_valid  out  1  EX result final this cycle
- wb_wr_en  out  1  wb_valid & registered wr_en
- wb_rd  out  4  registered rd

Behaviour:
- Reset: all registered outputs are 0 and the FSM is in IDLE. id_ready = 0 during reset.
- FSM states:
  - IDLE: EX empty.
  - RUN: EX holds a single-cycle op, or a multiply on its final cycle.
  - MWAIT: multiply not yet done; counter cnt counts down.
- id_ready = !resetn & !flush & (state != MWAIT). Transfer occurs when id_valid & id_ready.
- On transfer:
  - Load all id_ fields into the ex_ registers.
  - If id_mult & MULT_CYCLES>1, go to MWAIT with cnt = MULT_CYCLES-1. Otherwise go to RUN.
- No transfer, not MWAIT: go to IDLE and clear ex_valid. Data registers may keep old values.
- MWAIT: decrement cnt each cycle. At cnt==1 go to RUN. EX outputs are held constant throughout.
- ex_valid = (state != IDLE). wb_valid = (state == RUN).
- ex_PSR_Wen = registered PSR_Wen & wb_valid. Flags are written exactly once per instruction, and never by bubbles.
- Forwarding at transfer:
  - If wb_valid & reg wr_en & rd == id_rs_a, load ex_srcA from ex_data instead of id_srcA. Same rule for B.
  - A single match may forward to both operands.
  - immed_sel does not suppress srcA forwarding; EX selects.
  - No register is special-cased, including rd 0.
- Throughput: back-to-back single-cycle instructions issue one per cycle. A multiply blocks ID for MULT_CYCLES-1 cycles.
- Flush has priority over everything except reset:
  - Go to IDLE, clear ex_valid, cnt, and the PSR_Wen/wr_en registers.
  - The ID offer in that cycle is not consumed.
  - Flush in MWAIT aborts the multiply with no wb_valid.
- Reset mid-multiply behaves like flush and also zeroes all data registers.

Test Plan:
- Reset then idle: resetn=1 for 2 cycles, then release -> all outputs 0; id_ready=1 next cycle.
- Forward chain: issue ADD rd=3 (A=5,B=7, ex_data=12), then next cycle SUB rs_a=3, id_srcA=99 -> second ex_srcA=12; wb_valid high both cycles.
- Multiply stall, MULT_CYCLES=3: issue MUL with id_valid held -> id_ready low 2 cycles; wb_valid and ex_PSR_Wen high only on cycle 3; next instruction loads on cycle 4.
- Flush during MWAIT (cycle 2 of MUL) -> ex_valid=0 next cycle; no wb_valid/ex_PSR_Wen pulse; the ID instruction offered with flush is still pending afterward.
- Bubble: id_valid=0 after ADD with PSR_Wen=1 -> ex_PSR_Wen high exactly 1 cycle, then 0; wb_wr_en=0.
- MULT_CYCLES=1 build: MUL issues at full rate; id_ready never drops.
